// File: rtl/usr_tx_sequencer.sv
// usr_tx_sequencer: loads a handshaked word into the USR, shifts it right once per bit period
// and frames the USR LSB as start/data/parity/stop on a UART-style line.
module usr_tx_sequencer #(
   parameter int DATA_W     = 8,
   parameter int BAUD_DIV   = 4,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic              CLK,
   input  logic              clear,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [1:0]        usr_select,
   output logic [DATA_W-1:0] usr_data,
   output logic              usr_msb_in,
   input  logic              usr_q_lsb,
   output logic              tx_serial,
   output logic              busy,
   output logic              done
);
   localparam int BW = $clog2(BAUD_DIV);
   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

   state_t            state, state_nxt;
   logic [BW-1:0]     baud_cnt, baud_nxt;
   logic [CW-1:0]     bit_cnt, bit_nxt;
   logic [DATA_W-1:0] word;
   logic              par, serial_nxt, done_nxt, baud_last;

   assign baud_last  = baud_cnt == BAUD_LAST;
   assign tx_ready   = state == IDLE;
   assign busy       = state != IDLE;
   assign usr_msb_in = 1'b1;
   assign usr_data   = state == LOAD ? word : '0;
   // one right shift at the head of each data bit period keeps Q[0] one bit ahead of the line
   assign usr_select = state == LOAD ? 2'b11 : (state == DATA && baud_cnt == '0) ? 2'b01 : 2'b00;

   always_comb begin
      state_nxt  = state;
      baud_nxt   = (baud_last || state == IDLE || state == LOAD) ? '0 : baud_cnt + 1'b1;
      bit_nxt    = bit_cnt;
      serial_nxt = tx_serial;
      done_nxt   = 1'b0;
      case (state)
         IDLE: state_nxt = tx_valid ? LOAD : IDLE;
         LOAD: begin
            state_nxt  = START;
            serial_nxt = 1'b0;
         end
         START: if (baud_last) begin
            state_nxt  = DATA;
            bit_nxt    = '0;
            serial_nxt = usr_q_lsb;
         end
         DATA: if (baud_last) begin
            if (bit_cnt == BIT_LAST) begin
               state_nxt  = (PARITY_EN != 0) ? PARITY : STOP;
               bit_nxt    = '0;
               serial_nxt = (PARITY_EN != 0) ? par : 1'b1;
            end else begin
               bit_nxt    = bit_cnt + 1'b1;
               serial_nxt = usr_q_lsb;
            end
         end
         PARITY: if (baud_last) begin
            state_nxt  = STOP;
            bit_nxt    = '0;
            serial_nxt = 1'b1;
         end
         STOP: if (baud_last) begin
            if (bit_cnt == STOP_LAST) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else begin
               bit_nxt = bit_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge clear) begin
      if (!clear) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         word      <= '0;
         par       <= 1'b0;
         tx_serial <= 1'b1;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         baud_cnt  <= baud_nxt;
         bit_cnt   <= bit_nxt;
         tx_serial <= serial_nxt;
         done      <= done_nxt;
         if (tx_valid && tx_ready) begin
            word <= tx_data;
            par  <= (^tx_data) ^ (PARITY_ODD != 0);
         end
      end
   end
endmodule

// File: tb/tb_usr_tx_sequencer.sv
// tb_usr_tx_sequencer: four sequencer configurations, each driving a behavioural USR,
// checked cycle by cycle against a frame built from the word by plain arithmetic.
module tb_usr_tx_sequencer;
   localparam logic [3:0][3:0] BD = {4'd2, 4'd4, 4'd4, 4'd4};
   localparam logic [3:0]      PE = 4'b0110;
   localparam logic [3:0]      PO = 4'b0100;
   localparam logic [3:0][1:0] SB = {2'd2, 2'd1, 2'd1, 2'd1};

   logic            clk = 1'b0;
   logic            clear;
   logic [7:0]      tx_data;
   logic [3:0]      valid_v, ready_v, ser_v, busy_v, done_v, msb_v;
   logic [3:0][1:0] sel_v;
   logic [3:0][7:0] udata_v;
   int              n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : u
      logic [7:0] usr_q, usr_data;
      logic       msb;
      usr_tx_sequencer #(
         .DATA_W(8), .BAUD_DIV(int'(BD[g])), .PARITY_EN(int'(PE[g])),
         .PARITY_ODD(int'(PO[g])), .STOP_BITS(int'(SB[g]))
      ) dut (
         .CLK(clk), .clear(clear), .tx_data(tx_data), .tx_valid(valid_v[g]),
         .tx_ready(ready_v[g]), .usr_select(sel_v[g]), .usr_data(usr_data),
         .usr_msb_in(msb), .usr_q_lsb(usr_q[0]), .tx_serial(ser_v[g]),
         .busy(busy_v[g]), .done(done_v[g])
      );
      always_ff @(posedge clk or negedge clear)
         if (!clear) usr_q <= '0;
         else case (sel_v[g])
            2'b01:   usr_q <= {msb, usr_q[7:1]};
            2'b10:   usr_q <= {usr_q[6:0], 1'b0};
            2'b11:   usr_q <= usr_data;
            default: usr_q <= usr_q;
         endcase
      assign udata_v[g] = usr_data;
      assign msb_v[g]   = msb;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic check_idle(input int k, input string tag);
      check($sformatf("%s ser[%0d]", tag, k), ser_v[k], 1);
      check($sformatf("%s sel[%0d]", tag, k), sel_v[k], 0);
      check($sformatf("%s ready[%0d]", tag, k), ready_v[k], 1);
      check($sformatf("%s busy[%0d]", tag, k), busy_v[k], 0);
      check($sformatf("%s done[%0d]", tag, k), done_v[k], 0);
   endtask

   // Sends w on instance k and checks every cycle up to and including the done cycle.
   // With keep, tx_valid stays high carrying w_next so it is taken in the done cycle.
   task automatic run_frame(input int k, input logic [7:0] w, input logic [7:0] w_next, input bit keep);
      bit         q[$];
      int         bd, last, pulses, j, ph;
      bit         e_ser;
      logic [1:0] e_sel;
      bd = int'(BD[k]);
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(w[i]);
      if (PE[k]) q.push_back((^w) ^ PO[k]);
      for (int i = 0; i < int'(SB[k]); i++) q.push_back(1'b1);
      last = q.size() * bd + 1;
      pulses = 0;
      tx_data = w;
      valid_v[k] = 1'b1;
      @(posedge clk);
      for (int m = 0; m <= last; m++) begin
         @(negedge clk);
         if (m == 0) begin
            e_ser = 1'b1;
            e_sel = 2'b11;
         end else if (m == last) begin
            e_ser = 1'b1;
            e_sel = 2'b00;
         end else begin
            j = (m - 1) / bd;
            ph = (m - 1) % bd;
            e_ser = q[j];
            e_sel = (j >= 1 && j <= 8 && ph == 0) ? 2'b01 : 2'b00;
         end
         check($sformatf("ser[%0d] w=%h m=%0d", k, w, m), ser_v[k], e_ser);
         check($sformatf("sel[%0d] w=%h m=%0d", k, w, m), sel_v[k], e_sel);
         check($sformatf("busy[%0d] w=%h m=%0d", k, w, m), busy_v[k], m != last);
         check($sformatf("ready[%0d] w=%h m=%0d", k, w, m), ready_v[k], m == last);
         check($sformatf("done[%0d] w=%h m=%0d", k, w, m), done_v[k], m == last);
         if (m == 0) check($sformatf("usr_data[%0d] w=%h", k, w), udata_v[k], w);
         if (sel_v[k] == 2'b01) pulses++;
         if (m == 0) begin
            if (keep) tx_data = w_next;
            else valid_v[k] = 1'b0;
         end
      end
      check($sformatf("pulses[%0d] w=%h", k, w), pulses, 8);
   endtask

   initial begin
      clear = 1'b0;
      valid_v = '0;
      tx_data = '0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check_idle(k, "reset");
         check($sformatf("reset usr_data[%0d]", k), udata_v[k], 0);
         check($sformatf("msb_in[%0d]", k), msb_v[k], 1);
      end
      clear = 1'b1;
      @(negedge clk);
      run_frame(0, 8'hA6, 8'h00, 1'b0);
      run_frame(1, 8'hA6, 8'h00, 1'b0);
      run_frame(2, 8'hA6, 8'h00, 1'b0);
      run_frame(0, 8'h55, 8'h0F, 1'b1);
      run_frame(0, 8'h0F, 8'h00, 1'b0);
      run_frame(3, 8'hFF, 8'h00, 1'b0);
      // abort mid data bit 3, then a clean frame
      tx_data = 8'h3C;
      valid_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_v[0] = 1'b0;
      repeat (18) @(negedge clk);
      clear = 1'b0;
      #1;
      check_idle(0, "abort");
      @(negedge clk);
      clear = 1'b1;
      run_frame(0, 8'hC3, 8'h00, 1'b0);
      for (int t = 0; t < 24; t++) begin
         int k, nb;
         logic [7:0] w, wn;
         k = $urandom_range(0, 3);
         nb = $urandom_range(0, 2);
         w = 8'($urandom);
         for (int b = 0; b <= nb; b++) begin
            wn = 8'($urandom);
            run_frame(k, w, wn, b < nb);
            w = wn;
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
